bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Round-robin arbiter that shares one port of the dual-port block RAM among NREQ requesters. Each requester gets a valid/ready request channel and a one-cycle-latency response strobe. After reset, a built-in init sweep zero-fills the whole memory before any request is accepted. Sits between client engines and the BRAM port; the second BRAM port is left free for other users.

## Interface
- DATA, 32, word width; matches BRAM DATA
- ADDR, 10, address width; memory depth is 2**ADDR
- NREQ, 4, number of requesters (2..8)
- INIT_EN, 1, 1 = zero-fill memory after reset; 0 = skip the sweep

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_wr  in  NREQ  per-requester 1 = write, 0 = read
- req_addr  in  NREQ*ADDR  flattened addresses; requester i at [i*ADDR +: ADDR]
- req_din  in  NREQ*DATA  flattened write data; requester i at [i*DATA +: DATA]
- rsp_valid  out  NREQ  one-hot; response for the request requester i issued the previous cycle
- rsp_data  out  DATA  response data; equals bram_dout
- bram_wr  out  1  to BRAM port write enable
- bram_addr  out  ADDR  to BRAM port address
- bram_din  out  DATA  to BRAM port write data
- bram_dout  in  DATA  from BRAM port; registered by the BRAM, write-first
- init_done  out  1  high once the arbiter accepts requests

## Operation
- FSM states: INIT and SERVE.
- Reset behaviour:
  - On rst, the FSM goes to INIT if INIT_EN=1, else to SERVE.
  - Init counter, round-robin pointer and rsp_valid all clear to 0.
- INIT state:
  - bram_wr=1, bram_din=0, bram_addr=init counter.
  - The counter increments each cycle.
  - On the cycle it drives address 2**ADDR-1, the next state is SERVE.
  - req_ready=0 and rsp_valid=0 throughout.
- SERVE state:
  - init_done=1.
  - The winner is the lowest index at or after (last+1) mod NREQ with req_valid set.
  - "last" is the index of the most recent grant; after reset it is NREQ-1, so requester 0 has top priority.
  - req_ready is asserted only for the winner, combinationally from req_valid in the same cycle. A transfer occurs when valid && ready.
  - On grant, bram_wr/addr/din are driven combinationally from the winner's req_wr/addr/din. last becomes the winner's index.
  - With no valid requests: bram_wr=0, bram_addr holds its previous value, last is unchanged.
- Responses:
  - rsp_valid[i] is the registered grant for requester i.
  - rsp_data is the read data, or the write echo (write-first).
  - Writes also produce a response, which acts as a write acknowledge.
- Requesters must hold valid, wr, addr and din stable until ready. Dropping valid before ready is permitted and drops the request.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, init_done=0, bram_wr=0.
  - bram_addr=0, bram_din=0.
- Init sweep:
  - Occupies exactly 2**ADDR cycles, starting the first cycle after rst deasserts.
  - init_done rises the cycle after the last init write.
  - With INIT_EN=0, init_done rises the first cycle after rst deasserts.
- Latency and throughput:
  - Request accepted in cycle T → rsp_valid and rsp_data valid in cycle T+1, for one cycle only.
  - Back-to-back grants give one request and one response per cycle.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
- Read-after-write:
  - A write granted in T followed by a read of the same address granted in T+1 returns the new data in T+2.
  - A read and write to the same address cannot occur in the same cycle (single grant).
- Reset mid-operation:
  - Any in-flight response in the following cycle is suppressed (rsp_valid=0).
  - The FSM restarts INIT, and the memory is re-zeroed when INIT_EN=1.
- No response is ever generated for an ungranted request.

## Test plan
- Reset and init, ADDR=4, INIT_EN=1:
  - Stimulus: release rst, hold all req_valid=1.
  - Required: exactly 16 writes of 0 to addresses 0..15; req_ready=0 for those 16 cycles; init_done=1 on cycle 17; first grant goes to requester 0.
- Write then read:
  - Stimulus: requester 2 writes 0xDEADBEEF to addr 5, then reads addr 5.
  - Required: rsp_valid=4'b0100 one cycle after each grant; second rsp_data=0xDEADBEEF.
- Round-robin, all 4 requesters valid for 8 cycles:
  - Required: grant order 0,1,2,3,0,1,2,3; each rsp_valid one-hot, one cycle after its grant.
- Sparse requests:
  - Stimulus: only requesters 1 and 3 valid after last=1.
  - Required: grants alternate 3,1,3; requesters 0 and 2 never see ready.
- Reset mid-burst, INIT_EN=0:
  - Stimulus: assert rst the cycle after a read grant.
  - Required: rsp_valid=0 in the following cycle; next grant after rst goes to requester 0; unread memory contents keep their previous values.
- Unset memory after init:
  - Stimulus: read addr 15 after the sweep.
  - Required: rsp_data=0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters,
// with an optional zero-fill sweep of the memory after reset.
module bram_port_arbiter #(
  parameter int DATA    = 32,
  parameter int ADDR    = 10,
  parameter int NREQ    = 4,
  parameter int INIT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_din,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DATA-1:0]      rsp_data,
  output logic                 bram_wr,
  output logic [ADDR-1:0]      bram_addr,
  output logic [DATA-1:0]      bram_din,
  input  logic [DATA-1:0]      bram_dout,
  output logic                 init_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    INIT,
    SERVE
  } state_t;

  state_t          state;
  logic [ADDR-1:0] cnt;
  logic [ADDR-1:0] addr_q;
  logic [IW-1:0]   last;
  logic [NREQ-1:0] rsp_q;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win;
  logic            hit;
  logic            serve;
  logic            go;
  logic            in_init;

  assign serve   = (state == SERVE) && !rst;
  assign in_init = (state == INIT) && !rst;
  assign go      = serve && hit;

  // Scan starts one past the last winner so priority rotates.
  always_comb begin
    hit = 1'b0;
    win = last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!hit && req_valid[(int'(last) + k) % NREQ]) begin
        hit = 1'b1;
        win = IW'((int'(last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (go) grant[win] = 1'b1;
  end

  always_comb begin
    bram_wr   = 1'b0;
    bram_addr = addr_q;
    bram_din  = '0;
    unique case (1'b1)
      rst: begin
        bram_addr = '0;
      end
      in_init: begin
        bram_wr   = 1'b1;
        bram_addr = cnt;
      end
      go: begin
        bram_wr   = req_wr[win];
        bram_addr = req_addr[int'(win)*ADDR +: ADDR];
        bram_din  = req_din[int'(win)*DATA +: DATA];
      end
      default: ;
    endcase
  end

  assign req_ready = grant;
  assign init_done = serve;
  assign rsp_valid = rst ? '0 : rsp_q;
  assign rsp_data  = bram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= (INIT_EN != 0) ? INIT : SERVE;
      cnt    <= '0;
      addr_q <= '0;
      last   <= IW'(NREQ - 1);
      rsp_q  <= '0;
    end else begin
      rsp_q <= grant;
      unique case (state)
        INIT: begin
          addr_q <= cnt;
          cnt    <= cnt + 1'b1;
          if (cnt == '1) state <= SERVE;
        end
        SERVE: begin
          if (hit) begin
            last   <= win;
            addr_q <= bram_addr;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a write-first BRAM model
// and a response scoreboard; one DUT with init sweep, one without.
module tb_bram_port_arbiter;

  localparam int DATA = 32;
  localparam int ADDR = 4;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_a, rst_b, sel, preload;
  logic [NREQ-1:0] req_valid, req_wr;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_din;

  logic [NREQ-1:0] ready_a, rspv_a, ready_b, rspv_b;
  logic [DATA-1:0] rspd_a, bdin_a, bdout_a;
  logic [DATA-1:0] rspd_b, bdin_b, bdout_b;
  logic [ADDR-1:0] baddr_a, baddr_b;
  logic bwr_a, bwr_b, done_a, done_b;

  logic [NREQ-1:0] ready, rspv;
  logic [DATA-1:0] rspd, bdin;
  logic [ADDR-1:0] baddr;
  logic bwr, done;

  logic [DATA-1:0] mem_a [16];
  logic [DATA-1:0] mem_b [16];
  logic [DATA-1:0] refm [16];
  logic [35:0] sbq [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .DATA(DATA), .ADDR(ADDR), .NREQ(NREQ), .INIT_EN(1)
  ) dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(req_valid), .req_ready(ready_a),
    .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rspv_a), .rsp_data(rspd_a),
    .bram_wr(bwr_a), .bram_addr(baddr_a), .bram_din(bdin_a),
    .bram_dout(bdout_a), .init_done(done_a)
  );

  bram_port_arbiter #(
    .DATA(DATA), .ADDR(ADDR), .NREQ(NREQ), .INIT_EN(0)
  ) dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(req_valid), .req_ready(ready_b),
    .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rspv_b), .rsp_data(rspd_b),
    .bram_wr(bwr_b), .bram_addr(baddr_b), .bram_din(bdin_b),
    .bram_dout(bdout_b), .init_done(done_b)
  );

  assign ready = sel ? ready_b : ready_a;
  assign rspv  = sel ? rspv_b  : rspv_a;
  assign rspd  = sel ? rspd_b  : rspd_a;
  assign bdin  = sel ? bdin_b  : bdin_a;
  assign baddr = sel ? baddr_b : baddr_a;
  assign bwr   = sel ? bwr_b   : bwr_a;
  assign done  = sel ? done_b  : done_a;

  // Registered, write-first BRAM ports.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= 32'hA5A5_0000 | i;
        mem_b[i] <= 32'h0000_1000 + i;
      end
    end else begin
      if (bwr_a) begin
        mem_a[baddr_a] <= bdin_a;
        bdout_a <= bdin_a;
      end else begin
        bdout_a <= mem_a[baddr_a];
      end
      if (bwr_b) begin
        mem_b[baddr_b] <= bdin_b;
        bdout_b <= bdin_b;
      end else begin
        bdout_b <= mem_b[baddr_b];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setr(input int i, input logic wr,
                      input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    req_wr[i] = wr;
    req_addr[i*ADDR +: ADDR] = a;
    req_din[i*DATA +: DATA] = d;
  endtask

  task automatic cycle(input logic [NREQ-1:0] er);
    int g;
    logic [DATA-1:0] d;
    logic [ADDR-1:0] a;
    logic [35:0] e;
    g = 0;
    @(negedge clk);
    chk("init_done", done, 1);
    chk("req_ready", ready, er);
    if (er != 0) begin
      for (int i = 0; i < NREQ; i++) if (er[i]) g = i;
      a = req_addr[g*ADDR +: ADDR];
      chk("bram_wr", bwr, req_wr[g]);
      chk("bram_addr", baddr, a);
      if (req_wr[g]) begin
        d = req_din[g*DATA +: DATA];
        chk("bram_din", bdin, d);
        refm[a] = d;
      end else begin
        d = refm[a];
      end
      sbq.push_back({er, d});
    end
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rsp_valid", rspv, e[35:32]);
      chk("rsp_data", rspd, e[31:0]);
    end else begin
      chk("rsp_idle", rspv, 0);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    sel = 1'b0;
    preload = 1'b1;
    req_valid = '0;
    req_wr = '0;
    req_addr = '0;
    req_din = '0;
    for (int i = 0; i < 16; i++) refm[i] = '0;
    @(posedge clk);
    #1 preload = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    setr(0, 1'b0, 4'd0, 32'h0);
    setr(1, 1'b0, 4'd1, 32'h0);
    setr(2, 1'b0, 4'd2, 32'h0);
    setr(3, 1'b0, 4'd15, 32'h0);

    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_rspv", rspv, 0);
    chk("rst_done", done, 0);
    chk("rst_bram_wr", bwr, 0);
    chk("rst_bram_addr", baddr, 0);
    chk("rst_bram_din", bdin, 0);
    @(posedge clk);
    #1 rst_a = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init_wr", bwr, 1);
      chk("init_addr", baddr, i);
      chk("init_din", bdin, 0);
      chk("init_ready", ready, 0);
      chk("init_rspv", rspv, 0);
      chk("init_done_lo", done, 0);
      @(posedge clk);
      #1;
    end

    for (int r = 0; r < 8; r++) cycle(4'b0001 << (r % 4));

    req_valid = 4'b0100;
    setr(2, 1'b1, 4'd5, 32'hDEAD_BEEF);
    cycle(4'b0100);
    req_wr[2] = 1'b0;
    cycle(4'b0100);

    req_valid = 4'b0010;
    cycle(4'b0010);
    req_valid = 4'b1010;
    cycle(4'b1000);
    cycle(4'b0010);
    cycle(4'b1000);

    req_valid = 4'b0000;
    @(negedge clk);
    chk("idle_ready", ready, 0);
    chk("idle_bram_wr", bwr, 0);
    chk("idle_bram_addr", baddr, 15);
    @(posedge clk);
    #1;
    chk("idle_rspv", rspv, 0);

    rst_a = 1'b1;
    sel = 1'b1;
    for (int i = 0; i < 16; i++) refm[i] = 32'h0000_1000 + i;
    setr(0, 1'b1, 4'd2, 32'h0000_1111);
    setr(1, 1'b0, 4'd2, 32'h0);
    req_valid = 4'b0001;
    rst_b = 1'b0;
    cycle(4'b0001);

    req_valid = 4'b0010;
    @(negedge clk);
    chk("b_read_ready", ready, 4'b0010);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("midrst_rspv", rspv, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_done", done, 0);
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("postrst_rspv", rspv, 0);
    chk("postrst_done", done, 1);
    @(posedge clk);
    #1;

    req_valid = 4'b1111;
    setr(0, 1'b0, 4'd7, 32'h0);
    cycle(4'b0001);
    cycle(4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
